cga_mode_loader: RTL and testbench

- ISA I/O initiator that programs the CGA adapter into one of the seven standard BIOS video modes (0-6).
- Writes the mode control register, all 16 CRTC registers through the index/data pair, the colour select register, and finally re-enables video.
- Optionally polls the status register for the start of vertical retrace before the first write.
- Drives the same ISA I/O strobe/address/data lines the adapter decodes; used for BIOS-less bring-up and splash-screen exit.

---
 rtl/cga_mode_loader_pkg.sv | 74 +++++++
 rtl/cga_mode_loader_if.sv | 19 +
 rtl/cga_io_cycle.sv | 111 +++++++++++
 rtl/cga_mode_loader.sv | 171 +++++++++++++++++
 tb/tb_cga_mode_loader.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cga_mode_loader_pkg.sv
// Shared constants for the CGA mode loader: I/O offsets, FSM state types and the
// BIOS mode table with the helper that expands it into the 35-entry write list.
package cga_mode_loader_pkg;

   localparam logic [3:0] OFS_CRTC_INDEX = 4'h4;
   localparam logic [3:0] OFS_CRTC_DATA  = 4'h5;
   localparam logic [3:0] OFS_CONTROL    = 4'h8;
   localparam logic [3:0] OFS_COLOR      = 4'h9;
   localparam logic [3:0] OFS_STATUS     = 4'hA;

   localparam logic [7:0] STATUS_VRETRACE = 8'h08;
   localparam logic [7:0] CTRL_VIDEO_EN   = 8'h08;
   localparam logic [5:0] LAST_WRITE      = 6'd34;
   localparam logic [2:0] MODE_ILLEGAL    = 3'd7;

   // R0 occupies the top byte of each table.
   localparam logic [127:0] CRTC_TEXT40 = 128'h38282D0A_1F06191C_02070607_00000000;
   localparam logic [127:0] CRTC_TEXT80 = 128'h71505A0A_1F06191C_02070607_00000000;
   localparam logic [127:0] CRTC_GFX    = 128'h38282D0A_7F066470_02010607_00000000;

   typedef enum logic [1:0] {StIdle, StVwait, StWr, StFin} state_e;
   typedef enum logic [1:0] {CycIdle, CycSetup, CycStrobe, CycHold} cyc_state_e;

   typedef struct packed {
      logic [3:0] ofs;
      logic [7:0] data;
   } wr_entry_t;

   function automatic logic [7:0] mode_ctrl(input logic [2:0] mode);
      logic [7:0] c;
      case (mode)
         3'd0:    c = 8'h2C;
         3'd1:    c = 8'h28;
         3'd2:    c = 8'h2D;
         3'd3:    c = 8'h29;
         3'd4:    c = 8'h2A;
         3'd5:    c = 8'h2E;
         3'd6:    c = 8'h1E;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] mode_color(input logic [2:0] mode);
      return (mode == 3'd6) ? 8'h3F : 8'h30;
   endfunction

   function automatic logic [7:0] crtc_reg(input logic [2:0] mode, input logic [3:0] n);
      logic [127:0] tbl;
      if (mode <= 3'd1)      tbl = CRTC_TEXT40;
      else if (mode <= 3'd3) tbl = CRTC_TEXT80;
      else                   tbl = CRTC_GFX;
      return tbl[{~n, 3'b000} +: 8];
   endfunction

   function automatic wr_entry_t list_entry(input logic [2:0] mode, input logic [5:0] idx);
      wr_entry_t  e;
      logic [4:0] k;
      k = 5'(idx - 6'd1);
      if (idx == 6'd0) begin
         e = '{ofs: OFS_CONTROL, data: mode_ctrl(mode) & ~CTRL_VIDEO_EN};
      end else if (idx <= 6'd32) begin
         // Odd list positions select the register, even ones carry its value.
         if (k[0]) e = '{ofs: OFS_CRTC_DATA, data: crtc_reg(mode, k[4:1])};
         else      e = '{ofs: OFS_CRTC_INDEX, data: {4'h0, k[4:1]}};
      end else if (idx == 6'd33) begin
         e = '{ofs: OFS_COLOR, data: mode_color(mode)};
      end else begin
         e = '{ofs: OFS_CONTROL, data: mode_ctrl(mode)};
      end
      return e;
   endfunction

endpackage

// File: rtl/cga_mode_loader_if.sv
// ISA I/O bus lines shared between the loader (master) and the CGA adapter (slave).
interface cga_mode_loader_if;
   logic [14:0] bus_a;
   logic [7:0]  bus_d;
   logic [7:0]  bus_in;
   logic        bus_ior_l;
   logic        bus_iow_l;
   logic        bus_aen;

   modport master (
      output bus_a, bus_d, bus_ior_l, bus_iow_l, bus_aen,
      input  bus_in
   );

   modport slave (
      input  bus_a, bus_d, bus_ior_l, bus_iow_l, bus_aen,
      output bus_in
   );
endinterface

// File: rtl/cga_io_cycle.sv
// Runs one SETUP/STROBE/HOLD ISA I/O cycle per accepted request; ack marks HOLD,
// where a new request is accepted so cycles can run back to back.
module cga_io_cycle
   import cga_mode_loader_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES  = 2,
   parameter int unsigned STROBE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [14:0] addr,
   input  logic [7:0]  wdata,
   output logic        ack,
   output logic [7:0]  rdata,
   output logic [14:0] bus_a,
   output logic [7:0]  bus_d,
   output logic        bus_ior_l,
   output logic        bus_iow_l,
   output logic        bus_aen,
   input  logic [7:0]  bus_in
);

   cyc_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [14:0] a_q, a_d;
   logic [7:0]  d_q, d_d, rdata_q, rdata_d;
   logic        we_q, we_d, ior_q, ior_d, iow_q, iow_d, aen_q, aen_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      d_d     = d_q;
      we_d    = we_q;
      ior_d   = ior_q;
      iow_d   = iow_q;
      aen_d   = aen_q;
      rdata_d = rdata_q;
      unique case (state_q)
         CycIdle, CycHold: begin
            if (req) begin
               state_d = CycSetup;
               cnt_d   = 4'(SETUP_CYCLES - 1);
               a_d     = addr;
               d_d     = wdata;
               we_d    = we;
               aen_d   = 1'b0;
            end else if (state_q == CycHold) begin
               state_d = CycIdle;
               aen_d   = 1'b1;
            end
         end
         CycSetup: begin
            if (cnt_q == 4'd0) begin
               state_d = CycStrobe;
               cnt_d   = 4'(STROBE_CYCLES - 1);
               iow_d   = ~we_q;
               ior_d   = we_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         CycStrobe: begin
            if (cnt_q == 4'd0) begin
               state_d = CycHold;
               iow_d   = 1'b1;
               ior_d   = 1'b1;
               rdata_d = bus_in;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = CycIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CycIdle;
         cnt_q   <= 4'd0;
         a_q     <= 15'd0;
         d_q     <= 8'd0;
         we_q    <= 1'b0;
         ior_q   <= 1'b1;
         iow_q   <= 1'b1;
         aen_q   <= 1'b1;
         rdata_q <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         d_q     <= d_d;
         we_q    <= we_d;
         ior_q   <= ior_d;
         iow_q   <= iow_d;
         aen_q   <= aen_d;
         rdata_q <= rdata_d;
      end
   end

   assign ack       = (state_q == CycHold);
   assign rdata     = rdata_q;
   assign bus_a     = a_q;
   assign bus_d     = d_q;
   assign bus_ior_l = ior_q;
   assign bus_iow_l = iow_q;
   assign bus_aen   = aen_q;

endmodule

// File: rtl/cga_mode_loader.sv
// Programs a CGA adapter into BIOS mode 0-6 over ISA I/O, optionally after waiting
// for the start of vertical retrace.
module cga_mode_loader
   import cga_mode_loader_pkg::*;
#(
   parameter logic [15:0] IO_BASE_ADDR  = 16'h3d0,
   parameter int unsigned SETUP_CYCLES  = 2,
   parameter int unsigned STROBE_CYCLES = 4,
   parameter bit          WAIT_VSYNC    = 1'b1,
   parameter logic [23:0] VSYNC_TIMEOUT = 24'd1000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [2:0]         mode_sel,
   cga_mode_loader_if.master  bus,
   output logic               busy,
   output logic               done,
   output logic               err
);

   state_e      state_q, state_d;
   logic [2:0]  mode_q, mode_d;
   logic [5:0]  idx_q, idx_d;
   logic [23:0] tmo_q, tmo_d;
   logic        seen0_q, seen0_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic        io_req, io_we, io_ack, vretrace, found, expired;
   logic [3:0]  io_ofs;
   logic [7:0]  io_wdata, io_rdata;
   wr_entry_t   ent;

   assign vretrace = |(io_rdata & STATUS_VRETRACE);
   assign found    = io_ack && seen0_q && vretrace;
   assign expired  = (tmo_q >= VSYNC_TIMEOUT);

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      idx_d    = idx_q;
      tmo_d    = tmo_q;
      seen0_d  = seen0_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
      io_req   = 1'b0;
      io_we    = 1'b0;
      io_ofs   = OFS_STATUS;
      io_wdata = 8'h00;
      // In WR the request presented on ack is the entry after the one finishing.
      ent = list_entry((state_q == StIdle) ? mode_sel : mode_q,
                       (state_q == StWr) ? idx_q + 6'd1 : 6'd0);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               mode_d  = mode_sel;
               err_d   = 1'b0;
               idx_d   = 6'd0;
               tmo_d   = 24'd0;
               seen0_d = 1'b0;
               busy_d  = 1'b1;
               if (mode_sel == MODE_ILLEGAL) begin
                  err_d   = 1'b1;
                  state_d = StFin;
               end else if (WAIT_VSYNC) begin
                  io_req  = 1'b1;
                  state_d = StVwait;
               end else begin
                  io_req   = 1'b1;
                  io_we    = 1'b1;
                  io_ofs   = ent.ofs;
                  io_wdata = ent.data;
                  state_d  = StWr;
               end
            end
         end
         StVwait: begin
            if (!expired) tmo_d = tmo_q + 24'd1;
            if (io_ack) begin
               seen0_d = seen0_q | ~vretrace;
               if (found) begin
                  io_req   = 1'b1;
                  io_we    = 1'b1;
                  io_ofs   = ent.ofs;
                  io_wdata = ent.data;
                  idx_d    = 6'd0;
                  state_d  = StWr;
               end else if (expired) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StFin;
               end else begin
                  io_req = 1'b1;
               end
            end
         end
         StWr: begin
            if (io_ack) begin
               if (idx_q == LAST_WRITE) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StFin;
               end else begin
                  io_req   = 1'b1;
                  io_we    = 1'b1;
                  io_ofs   = ent.ofs;
                  io_wdata = ent.data;
                  idx_d    = idx_q + 6'd1;
               end
            end
         end
         StFin: begin
            // A rejected mode arrives here still busy and emits its done pulse now.
            if (busy_q) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         mode_q  <= 3'd0;
         idx_q   <= 6'd0;
         tmo_q   <= 24'd0;
         seen0_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         seen0_q <= seen0_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

   cga_io_cycle #(
      .SETUP_CYCLES  (SETUP_CYCLES),
      .STROBE_CYCLES (STROBE_CYCLES)
   ) u_io_cycle (
      .clk       (clk),
      .reset     (reset),
      .req       (io_req),
      .we        (io_we),
      .addr      (IO_BASE_ADDR[14:0] + {11'd0, io_ofs}),
      .wdata     (io_wdata),
      .ack       (io_ack),
      .rdata     (io_rdata),
      .bus_a     (bus.bus_a),
      .bus_d     (bus.bus_d),
      .bus_ior_l (bus.bus_ior_l),
      .bus_iow_l (bus.bus_iow_l),
      .bus_aen   (bus.bus_aen),
      .bus_in    (bus.bus_in)
   );

endmodule

// File: tb/tb_cga_mode_loader.sv
// Bench for cga_mode_loader: three instances (no retrace wait, retrace wait, short
// timeout) watched by a CGA register model that decodes the write strobes.
module tb_cga_mode_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start0, start1, start2;
   logic [2:0] mode0, mode1, mode2;
   logic       busy0, done0, err0, busy1, done1, err1, busy2, done2, err2;

   cga_mode_loader_if bus0 ();
   cga_mode_loader_if bus1 ();
   cga_mode_loader_if bus2 ();

   always #5 clk = ~clk;

   cga_mode_loader #(.WAIT_VSYNC(1'b0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .mode_sel(mode0), .bus(bus0),
      .busy(busy0), .done(done0), .err(err0));
   cga_mode_loader #(.WAIT_VSYNC(1'b1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .mode_sel(mode1), .bus(bus1),
      .busy(busy1), .done(done1), .err(err1));
   cga_mode_loader #(.WAIT_VSYNC(1'b1), .VSYNC_TIMEOUT(24'd100)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .mode_sel(mode2), .bus(bus2),
      .busy(busy2), .done(done2), .err(err2));

   // Status bit3: high for reads 1-3, low on read 4, high again from read 5.
   int rd_cnt[3] = '{0, 0, 0};
   assign bus0.bus_in = 8'h00;
   assign bus1.bus_in = (rd_cnt[1] == 4) ? 8'h00 : 8'h08;
   assign bus2.bus_in = 8'h00;

   logic        iow_w[3], ior_w[3];
   logic [14:0] a_w[3];
   logic [7:0]  d_w[3];
   assign iow_w[0] = bus0.bus_iow_l;  assign ior_w[0] = bus0.bus_ior_l;
   assign iow_w[1] = bus1.bus_iow_l;  assign ior_w[1] = bus1.bus_ior_l;
   assign iow_w[2] = bus2.bus_iow_l;  assign ior_w[2] = bus2.bus_ior_l;
   assign a_w[0] = bus0.bus_a;  assign d_w[0] = bus0.bus_d;
   assign a_w[1] = bus1.bus_a;  assign d_w[1] = bus1.bus_d;
   assign a_w[2] = bus2.bus_a;  assign d_w[2] = bus2.bus_d;

   int          wr_cnt[3] = '{0, 0, 0};
   int          bad_width[3] = '{0, 0, 0};
   int          overlap[3] = '{0, 0, 0};
   int          low_run[3] = '{0, 0, 0};
   int          first_wr_rd[3] = '{-1, -1, -1};
   logic        iow_prev[3] = '{1'b1, 1'b1, 1'b1};
   logic        ior_prev[3] = '{1'b1, 1'b1, 1'b1};
   logic [7:0]  ctrl_m[3], col_m[3];
   logic [3:0]  idx_m[3];
   logic [7:0]  crtc_m[3][16];
   logic [14:0] log_a[1024];
   logic [7:0]  log_d[1024];

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            low_run[i]  = 0;
            iow_prev[i] = 1'b1;
            ior_prev[i] = 1'b1;
         end else begin
            if (!iow_w[i] && !ior_w[i]) overlap[i]++;
            if (!iow_w[i]) begin
               if (iow_prev[i]) begin
                  if (i == 0 && wr_cnt[0] < 1024) begin
                     log_a[wr_cnt[0]] = a_w[0];
                     log_d[wr_cnt[0]] = d_w[0];
                  end
                  if (wr_cnt[i] == 0) first_wr_rd[i] = rd_cnt[i];
                  wr_cnt[i]++;
                  case (a_w[i])
                     15'h3D4: idx_m[i] = d_w[i][3:0];
                     15'h3D5: crtc_m[i][idx_m[i]] = d_w[i];
                     15'h3D8: ctrl_m[i] = d_w[i];
                     15'h3D9: col_m[i] = d_w[i];
                     default: ;
                  endcase
               end
               low_run[i]++;
            end else if (!iow_prev[i]) begin
               if (low_run[i] != 4) bad_width[i]++;
               low_run[i] = 0;
            end
            if (!ior_w[i] && ior_prev[i]) rd_cnt[i]++;
            iow_prev[i] = iow_w[i];
            ior_prev[i] = ior_w[i];
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run0(input logic [2:0] m, output int lat);
      @(negedge clk);
      mode0  = m;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      lat    = 0;
      while (!done0 && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   typedef struct {
      logic [2:0] mode;
      logic [7:0] ctrl, col, r0, r1, r4, r6, r7, r9;
   } vec_t;

   vec_t       vecs[7];
   logic [7:0] r_mode3[16];
   int         lat, base, k;

   initial begin
      vecs[0] = '{3'd0, 8'h2C, 8'h30, 8'h38, 8'h28, 8'h1F, 8'h19, 8'h1C, 8'h07};
      vecs[1] = '{3'd1, 8'h28, 8'h30, 8'h38, 8'h28, 8'h1F, 8'h19, 8'h1C, 8'h07};
      vecs[2] = '{3'd2, 8'h2D, 8'h30, 8'h71, 8'h50, 8'h1F, 8'h19, 8'h1C, 8'h07};
      vecs[3] = '{3'd3, 8'h29, 8'h30, 8'h71, 8'h50, 8'h1F, 8'h19, 8'h1C, 8'h07};
      vecs[4] = '{3'd4, 8'h2A, 8'h30, 8'h38, 8'h28, 8'h7F, 8'h64, 8'h70, 8'h01};
      vecs[5] = '{3'd5, 8'h2E, 8'h30, 8'h38, 8'h28, 8'h7F, 8'h64, 8'h70, 8'h01};
      vecs[6] = '{3'd6, 8'h1E, 8'h3F, 8'h38, 8'h28, 8'h7F, 8'h64, 8'h70, 8'h01};
      r_mode3 = '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
                  8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};

      reset = 1'b1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      mode0 = 3'd0;  mode1 = 3'd0;  mode2 = 3'd0;
      #12;
      check("reset bus_a", int'(bus0.bus_a), 0);
      check("reset bus_d", int'(bus0.bus_d), 0);
      check("reset ior_l", int'(bus0.bus_ior_l), 1);
      check("reset iow_l", int'(bus0.bus_iow_l), 1);
      check("reset aen", int'(bus0.bus_aen), 1);
      check("reset busy/done/err", int'({busy0, done0, err0}), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Illegal mode: one busy cycle, done next, err sticky, no bus activity.
      base = wr_cnt[0];
      k    = rd_cnt[0];
      @(negedge clk);
      mode0  = 3'd7;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      check("mode7 busy cycle0", int'(busy0), 1);
      check("mode7 done cycle0", int'(done0), 0);
      @(negedge clk);
      check("mode7 done cycle1", int'(done0), 1);
      check("mode7 busy cycle1", int'(busy0), 0);
      check("mode7 err", int'(err0), 1);
      repeat (20) @(negedge clk);
      check("mode7 no writes", wr_cnt[0] - base, 0);
      check("mode7 no reads", rd_cnt[0] - k, 0);
      check("mode7 err sticky", int'(err0), 1);
      check("mode7 aen idle", int'(bus0.bus_aen), 1);

      foreach (vecs[v]) begin
         base = wr_cnt[0];
         run0(vecs[v].mode, lat);
         check($sformatf("m%0d done latency", v), lat, 245);
         check($sformatf("m%0d write count", v), wr_cnt[0] - base, 35);
         check($sformatf("m%0d err", v), int'(err0), 0);
         check($sformatf("m%0d ctrl", v), int'(ctrl_m[0]), int'(vecs[v].ctrl));
         check($sformatf("m%0d colour", v), int'(col_m[0]), int'(vecs[v].col));
         check($sformatf("m%0d R0", v), int'(crtc_m[0][0]), int'(vecs[v].r0));
         check($sformatf("m%0d R1", v), int'(crtc_m[0][1]), int'(vecs[v].r1));
         check($sformatf("m%0d R4", v), int'(crtc_m[0][4]), int'(vecs[v].r4));
         check($sformatf("m%0d R6", v), int'(crtc_m[0][6]), int'(vecs[v].r6));
         check($sformatf("m%0d R7", v), int'(crtc_m[0][7]), int'(vecs[v].r7));
         check($sformatf("m%0d R9", v), int'(crtc_m[0][9]), int'(vecs[v].r9));
      end

      // Exact write order for mode 3.
      base = wr_cnt[0];
      run0(3'd3, lat);
      check("seq count", wr_cnt[0] - base, 35);
      check("seq w1 addr", int'(log_a[base]), 'h3D8);
      check("seq w1 data", int'(log_d[base]), 'h21);
      for (int n = 0; n < 16; n++) begin
         check($sformatf("seq idx%0d addr", n), int'(log_a[base + 1 + 2 * n]), 'h3D4);
         check($sformatf("seq idx%0d data", n), int'(log_d[base + 1 + 2 * n]), n);
         check($sformatf("seq R%0d addr", n), int'(log_a[base + 2 + 2 * n]), 'h3D5);
         check($sformatf("seq R%0d data", n), int'(log_d[base + 2 + 2 * n]), int'(r_mode3[n]));
      end
      check("seq w34 addr", int'(log_a[base + 33]), 'h3D9);
      check("seq w34 data", int'(log_d[base + 33]), 'h30);
      check("seq w35 addr", int'(log_a[base + 34]), 'h3D8);
      check("seq w35 data", int'(log_d[base + 34]), 'h29);
      repeat (3) @(negedge clk);
      check("idle aen", int'(bus0.bus_aen), 1);
      check("idle holds addr", int'(bus0.bus_a), 'h3D8);
      check("idle holds data", int'(bus0.bus_d), 'h29);

      // Retrace wait: five status reads before the first write.
      @(negedge clk);
      mode1  = 3'd6;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lat    = 0;
      while (!done1 && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
      check("vsync done latency", lat, 280);
      check("vsync reads", rd_cnt[1], 5);
      check("vsync reads before 1st write", first_wr_rd[1], 5);
      check("vsync write count", wr_cnt[1], 35);
      check("vsync ctrl", int'(ctrl_m[1]), 'h1E);
      check("vsync colour", int'(col_m[1]), 'h3F);
      check("vsync err", int'(err1), 0);

      // Retrace timeout: bit3 stuck low.
      @(negedge clk);
      mode2  = 3'd3;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      lat    = 0;
      while (!done2 && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
      check("timeout done latency", lat, 105);
      check("timeout err", int'(err2), 1);
      check("timeout reads", rd_cnt[2], 15);
      repeat (50) @(negedge clk);
      check("timeout no writes", wr_cnt[2], 0);
      check("timeout no reads after done", rd_cnt[2], 15);

      // Reset during write 10 drops the strobe at once; a fresh start reloads fully.
      base = wr_cnt[0];
      @(negedge clk);
      mode0  = 3'd3;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      k      = 0;
      while (wr_cnt[0] - base < 10 && k < 500) begin
         @(negedge clk);
         k++;
      end
      check("write 10 strobe low", int'(bus0.bus_iow_l), 0);
      #2 reset = 1'b1;
      #1;
      check("async reset iow_l", int'(bus0.bus_iow_l), 1);
      check("async reset aen", int'(bus0.bus_aen), 1);
      check("async reset busy", int'(busy0), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      base  = wr_cnt[0];
      run0(3'd3, lat);
      check("reload latency", lat, 245);
      check("reload write count", wr_cnt[0] - base, 35);
      check("reload ctrl", int'(ctrl_m[0]), 'h29);
      check("reload R0", int'(crtc_m[0][0]), 'h71);
      repeat (5) @(negedge clk);
      check("iow pulse widths", bad_width[0] + bad_width[1], 0);
      check("strobe overlap", overlap[0] + overlap[1] + overlap[2], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected end before 2 ms");
      $fatal(1, "watchdog");
   end

endmodule
